// File: rtl/range_pkg.sv
// Shared types and helpers for the multi-channel range finder.
package range_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } range_state_t;

  // Channel-id width; a single channel still needs one bit of id.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/range_channel.sv
// One channel's go/finish session FSM with min/max/count accumulators.
module range_channel
  import range_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned SIGNED    = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 hit,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 go,
  input  logic                 finish,
  output logic [WIDTH-1:0]     res_min_c,
  output logic [WIDTH-1:0]     res_max_c,
  output logic [CNT_WIDTH-1:0] res_count_c,
  output logic                 result_fire_c,
  output logic                 err_fire_c,
  output logic                 busy
);

  localparam logic [WIDTH-1:0] TYPE_MAX = (SIGNED != 0) ? ~(WIDTH'(1) << (WIDTH - 1)) : '1;
  localparam logic [WIDTH-1:0] TYPE_MIN = (SIGNED != 0) ?  (WIDTH'(1) << (WIDTH - 1)) : '0;

  range_state_t          state_q, state_d;
  logic [WIDTH-1:0]      min_q, min_d, max_q, max_d, new_min, new_max;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;

  function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) < $signed(b);
    else             return a < b;
  endfunction

  // Accumulators as they would stand with this cycle's sample folded in.
  assign new_min = lt(data_in, min_q) ? data_in : min_q;
  assign new_max = lt(max_q, data_in) ? data_in : max_q;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      min_q   <= TYPE_MAX;
      max_q   <= TYPE_MIN;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d       = state_q;
    min_d         = min_q;
    max_d         = max_q;
    cnt_d         = cnt_q;
    result_fire_c = 1'b0;
    err_fire_c    = 1'b0;
    res_min_c     = new_min;
    res_max_c     = new_max;
    res_count_c   = cnt_inc;
    if (hit) begin
      unique case (state_q)
        IDLE: begin
          if (go && !finish) begin
            state_d = RUN;
            min_d   = data_in;
            max_d   = data_in;
            cnt_d   = CNT_WIDTH'(1);
          end else if (go && finish) begin
            result_fire_c = 1'b1;
            res_min_c     = data_in;
            res_max_c     = data_in;
            res_count_c   = CNT_WIDTH'(1);
          end else if (finish) begin
            state_d    = ERROR;
            err_fire_c = 1'b1;
          end
        end
        RUN: begin
          if (!go && !finish) begin
            min_d = new_min;
            max_d = new_max;
            cnt_d = cnt_inc;
          end else if (finish && !go) begin
            result_fire_c = 1'b1;
            state_d       = IDLE;
            min_d         = TYPE_MAX;
            max_d         = TYPE_MIN;
            cnt_d         = '0;
          end else if (go && !finish) begin
            min_d = data_in;
            max_d = data_in;
            cnt_d = CNT_WIDTH'(1);
          end else begin
            state_d    = ERROR;
            err_fire_c = 1'b1;
            min_d      = TYPE_MAX;
            max_d      = TYPE_MIN;
            cnt_d      = '0;
          end
        end
        ERROR: begin
          if (go && !finish) begin
            state_d = RUN;
            min_d   = data_in;
            max_d   = data_in;
            cnt_d   = CNT_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/multi_range_finder.sv
// Multi-channel running min/max/count tracker on a shared time-multiplexed sample bus.
module multi_range_finder
  import range_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned SIGNED    = 0,
  localparam int unsigned CH_W     = ch_width(CHANNELS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_valid,
  input  logic [CH_W-1:0]      chan,
  input  logic                 go,
  input  logic                 finish,
  output logic                 result_valid,
  output logic [CH_W-1:0]      result_chan,
  output logic [WIDTH-1:0]     range,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     max_out,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 error,
  output logic [CHANNELS-1:0]  chan_busy
);

  typedef struct packed {
    logic [CH_W-1:0]      chan;
    logic [WIDTH-1:0]     range;
    logic [WIDTH-1:0]     min;
    logic [WIDTH-1:0]     max;
    logic [CNT_WIDTH-1:0] count;
  } result_t;

  logic [CHANNELS-1:0]  hit, fire, err_fire, busy;
  logic [WIDTH-1:0]     ch_min [CHANNELS];
  logic [WIDTH-1:0]     ch_max [CHANNELS];
  logic [CNT_WIDTH-1:0] ch_cnt [CHANNELS];
  logic [WIDTH-1:0]     sel_min, sel_max;
  logic [CNT_WIDTH-1:0] sel_cnt;
  logic                 bad_chan, any_fire, any_err;
  result_t              rec_q;
  logic                 valid_q, error_q;

  assign bad_chan = data_valid && (32'(chan) >= CHANNELS);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign hit[i] = data_valid && (chan == CH_W'(i));

    range_channel #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .SIGNED    (SIGNED)
    ) u_ch (
      .clock         (clock),
      .reset_n       (reset_n),
      .hit           (hit[i]),
      .data_in       (data_in),
      .go            (go),
      .finish        (finish),
      .res_min_c     (ch_min[i]),
      .res_max_c     (ch_max[i]),
      .res_count_c   (ch_cnt[i]),
      .result_fire_c (fire[i]),
      .err_fire_c    (err_fire[i]),
      .busy          (busy[i])
    );
  end

  // Only the addressed channel can fire, so a plain select is enough.
  always_comb begin
    sel_min = '0;
    sel_max = '0;
    sel_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (fire[i]) begin
        sel_min = ch_min[i];
        sel_max = ch_max[i];
        sel_cnt = ch_cnt[i];
      end
    end
  end

  assign any_fire = |fire;
  assign any_err  = (|err_fire) || bad_chan;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rec_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= any_fire;
      error_q <= any_err;
      if (any_fire || any_err) rec_q.chan <= chan;
      if (any_fire) begin
        rec_q.min   <= sel_min;
        rec_q.max   <= sel_max;
        rec_q.range <= sel_max - sel_min;
        rec_q.count <= sel_cnt;
      end
    end
  end

  assign result_valid = valid_q;
  assign error        = error_q;
  assign result_chan  = rec_q.chan;
  assign range        = rec_q.range;
  assign min_out      = rec_q.min;
  assign max_out      = rec_q.max;
  assign count        = rec_q.count;
  assign chan_busy    = busy;

endmodule

// File: tb/tb_multi_range_finder.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, randomized model check.
module tb_multi_range_finder;

  bit clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: 16-bit unsigned, 4 channels, 16-bit counter
  logic [15:0] a_data;
  logic        a_valid, a_go, a_fin;
  logic [1:0]  a_chan;
  logic        a_rv, a_err;
  logic [1:0]  a_rc;
  logic [15:0] a_range, a_min, a_max, a_cnt;
  logic [3:0]  a_busy;

  // Instance B: 8-bit signed, 3 channels, 3-bit counter
  logic [7:0]  b_data;
  logic        b_valid, b_go, b_fin;
  logic [1:0]  b_chan;
  logic        b_rv, b_err;
  logic [1:0]  b_rc;
  logic [7:0]  b_range, b_min, b_max;
  logic [2:0]  b_cnt;
  logic [2:0]  b_busy;

  multi_range_finder dut_a (
    .clock(clk), .reset_n(rst_n), .data_in(a_data), .data_valid(a_valid),
    .chan(a_chan), .go(a_go), .finish(a_fin), .result_valid(a_rv),
    .result_chan(a_rc), .range(a_range), .min_out(a_min), .max_out(a_max),
    .count(a_cnt), .error(a_err), .chan_busy(a_busy)
  );

  multi_range_finder #(.WIDTH(8), .CHANNELS(3), .CNT_WIDTH(3), .SIGNED(1)) dut_b (
    .clock(clk), .reset_n(rst_n), .data_in(b_data), .data_valid(b_valid),
    .chan(b_chan), .go(b_go), .finish(b_fin), .result_valid(b_rv),
    .result_chan(b_rc), .range(b_range), .min_out(b_min), .max_out(b_max),
    .count(b_cnt), .error(b_err), .chan_busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic [1:0] c, input logic g, input logic f,
                        input logic [15:0] d);
    @(negedge clk);
    a_valid = v; a_chan = c; a_go = g; a_fin = f; a_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic [1:0] c, input logic g, input logic f,
                        input logic [7:0] d);
    @(negedge clk);
    b_valid = v; b_chan = c; b_go = g; b_fin = f; b_data = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  ch;
    logic        go, fin;
    logic [15:0] d;
    logic        rv, er;
    logic [1:0]  rc;
    logic [15:0] mn, mx, rg, ct;
    logic [3:0]  busy;
  } vec_t;

  vec_t tbl [25];

  // Reference model state: per-channel mode and the samples of the open session
  int          mode [4];
  int unsigned sq [4][$];
  logic        e_rv, e_er;
  logic [1:0]  e_rc;
  logic [15:0] e_min, e_max, e_rg, e_ct;

  task automatic emit(input int c);
    int unsigned mn, mx;
    int n;
    mn = 32'hFFFF_FFFF;
    mx = 0;
    foreach (sq[c][k]) begin
      if (sq[c][k] < mn) mn = sq[c][k];
      if (sq[c][k] > mx) mx = sq[c][k];
    end
    n     = sq[c].size();
    e_rv  = 1'b1;
    e_rc  = 2'(c);
    e_min = 16'(mn);
    e_max = 16'(mx);
    e_rg  = 16'(mx - mn);
    e_ct  = (n > 65535) ? 16'hFFFF : 16'(n);
    sq[c].delete();
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_chan = 0; a_go = 0; a_fin = 0; a_data = 0;
    b_valid = 0; b_chan = 0; b_go = 0; b_fin = 0; b_data = 0;

    //          v  ch go fn  d    rv er rc  mn   mx   rg  ct  busy
    tbl[0]  = '{1, 2, 1, 0,  5,   0, 0, 0,  0,   0,   0,  0, 4'b0100};
    tbl[1]  = '{1, 2, 0, 0,  9,   0, 0, 0,  0,   0,   0,  0, 4'b0100};
    tbl[2]  = '{1, 2, 0, 0,  3,   0, 0, 0,  0,   0,   0,  0, 4'b0100};
    tbl[3]  = '{1, 2, 0, 1,  7,   1, 0, 2,  3,   9,   6,  4, 4'b0000};
    tbl[4]  = '{1, 0, 1, 0,  100, 0, 0, 0,  0,   0,   0,  0, 4'b0001};
    tbl[5]  = '{1, 1, 1, 0,  1,   0, 0, 0,  0,   0,   0,  0, 4'b0011};
    tbl[6]  = '{1, 1, 0, 0,  2,   0, 0, 0,  0,   0,   0,  0, 4'b0011};
    tbl[7]  = '{1, 0, 0, 1,  40,  1, 0, 0,  40,  100, 60, 2, 4'b0010};
    tbl[8]  = '{1, 1, 0, 1,  3,   1, 0, 1,  1,   3,   2,  3, 4'b0000};
    tbl[9]  = '{1, 3, 0, 1,  0,   0, 1, 3,  0,   0,   0,  0, 4'b0000};
    tbl[10] = '{1, 3, 0, 1,  0,   0, 0, 0,  0,   0,   0,  0, 4'b0000};
    tbl[11] = '{1, 3, 1, 0,  10,  0, 0, 0,  0,   0,   0,  0, 4'b1000};
    tbl[12] = '{1, 3, 0, 1,  4,   1, 0, 3,  4,   10,  6,  2, 4'b0000};
    tbl[13] = '{1, 0, 1, 0,  7,   0, 0, 0,  0,   0,   0,  0, 4'b0001};
    tbl[14] = '{1, 0, 1, 1,  8,   0, 1, 0,  0,   0,   0,  0, 4'b0000};
    tbl[15] = '{0, 0, 0, 1,  0,   0, 0, 0,  0,   0,   0,  0, 4'b0000};
    tbl[16] = '{1, 0, 1, 1,  0,   0, 0, 0,  0,   0,   0,  0, 4'b0000};
    tbl[17] = '{1, 1, 1, 0,  50,  0, 0, 0,  0,   0,   0,  0, 4'b0010};
    tbl[18] = '{1, 1, 0, 0,  20,  0, 0, 0,  0,   0,   0,  0, 4'b0010};
    tbl[19] = '{1, 1, 1, 0,  30,  0, 0, 0,  0,   0,   0,  0, 4'b0010};
    tbl[20] = '{1, 1, 0, 1,  60,  1, 0, 1,  30,  60,  30, 2, 4'b0000};
    tbl[21] = '{1, 2, 1, 1,  77,  1, 0, 2,  77,  77,  0,  1, 4'b0000};
    tbl[22] = '{1, 2, 0, 0,  5,   0, 0, 0,  0,   0,   0,  0, 4'b0000};
    tbl[23] = '{1, 0, 1, 0,  9,   0, 0, 0,  0,   0,   0,  0, 4'b0001};
    tbl[24] = '{1, 0, 0, 1,  11,  1, 0, 0,  9,   11,  2,  2, 4'b0000};

    repeat (2) @(posedge clk);
    #1;
    chk("reset a_rv",    32'(a_rv),    0);
    chk("reset a_err",   32'(a_err),   0);
    chk("reset a_busy",  32'(a_busy),  0);
    chk("reset a_min",   32'(a_min),   0);
    chk("reset b_range", 32'(b_range), 0);
    chk("reset b_busy",  32'(b_busy),  0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step_a(tbl[i].v, tbl[i].ch, tbl[i].go, tbl[i].fin, tbl[i].d);
      chk($sformatf("vec%0d rv", i),   32'(a_rv),   32'(tbl[i].rv));
      chk($sformatf("vec%0d err", i),  32'(a_err),  32'(tbl[i].er));
      chk($sformatf("vec%0d busy", i), 32'(a_busy), 32'(tbl[i].busy));
      if (tbl[i].rv || tbl[i].er)
        chk($sformatf("vec%0d chan", i), 32'(a_rc), 32'(tbl[i].rc));
      if (tbl[i].rv) begin
        chk($sformatf("vec%0d min", i),   32'(a_min),   32'(tbl[i].mn));
        chk($sformatf("vec%0d max", i),   32'(a_max),   32'(tbl[i].mx));
        chk($sformatf("vec%0d range", i), 32'(a_range), 32'(tbl[i].rg));
        chk($sformatf("vec%0d count", i), 32'(a_cnt),   32'(tbl[i].ct));
      end
    end
    step_a(0, 0, 0, 0, 0);
    chk("held a_min", 32'(a_min), 9);

    // Signed extremes
    step_b(1, 0, 1, 0, 8'h80);
    step_b(1, 0, 0, 1, 8'h7F);
    chk("signed rv",    32'(b_rv),    1);
    chk("signed min",   32'(b_min),   32'h80);
    chk("signed max",   32'(b_max),   32'h7F);
    chk("signed range", 32'(b_range), 32'hFF);
    chk("signed count", 32'(b_cnt),   2);

    // Counter saturation at 3 bits
    step_b(1, 1, 1, 0, 8'd1);
    for (int k = 0; k < 9; k++) step_b(1, 1, 0, 0, 8'(k));
    chk("sat busy", 32'(b_busy), 3'b010);
    step_b(1, 1, 0, 1, 8'd5);
    chk("sat rv",    32'(b_rv),    1);
    chk("sat count", 32'(b_cnt),   7);
    chk("sat range", 32'(b_range), 8);

    // Out-of-range channel id
    step_b(1, 3, 1, 0, 8'd42);
    chk("badch err",  32'(b_err),  1);
    chk("badch chan", 32'(b_rc),   3);
    chk("badch rv",   32'(b_rv),   0);
    chk("badch busy", 32'(b_busy), 0);

    // Reset mid-session discards everything immediately
    step_b(1, 1, 1, 0, 8'd4);
    chk("pre-reset busy", 32'(b_busy), 3'b010);
    step_b(0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async b_busy",  32'(b_busy),  0);
    chk("async b_chan",  32'(b_rc),    0);
    chk("async b_min",   32'(b_min),   0);
    chk("async b_max",   32'(b_max),   0);
    chk("async b_range", 32'(b_range), 0);
    chk("async b_count", 32'(b_cnt),   0);
    chk("async a_min",   32'(a_min),   0);
    chk("async a_count", 32'(a_cnt),   0);
    @(negedge clk);
    rst_n = 1'b1;
    step_b(1, 1, 0, 1, 8'd9);
    chk("post-reset err",  32'(b_err), 1);
    chk("post-reset chan", 32'(b_rc),  1);
    chk("post-reset rv",   32'(b_rv),  0);
    step_b(0, 0, 0, 0, 0);

    // Randomized traffic on A against the session model
    for (int c = 0; c < 4; c++) begin
      mode[c] = 0;
      sq[c].delete();
    end
    e_rc = 0; e_min = 0; e_max = 0; e_rg = 0; e_ct = 0;
    for (int it = 0; it < 400; it++) begin
      logic        v, g, f;
      int          c;
      logic [15:0] d;
      v = ($urandom_range(0, 4) != 0);
      c = int'($urandom_range(0, 3));
      g = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      e_rv = 1'b0;
      e_er = 1'b0;
      if (v) begin
        case (mode[c])
          0: begin
            if (g && !f) begin
              mode[c] = 1; sq[c].delete(); sq[c].push_back(32'(d));
            end else if (g && f) begin
              sq[c].delete(); sq[c].push_back(32'(d)); emit(c);
            end else if (f) begin
              mode[c] = 2; e_er = 1'b1; e_rc = 2'(c);
            end
          end
          1: begin
            if (!g && !f) sq[c].push_back(32'(d));
            else if (f && !g) begin
              sq[c].push_back(32'(d)); emit(c); mode[c] = 0;
            end else if (g && !f) begin
              sq[c].delete(); sq[c].push_back(32'(d));
            end else begin
              mode[c] = 2; e_er = 1'b1; e_rc = 2'(c); sq[c].delete();
            end
          end
          default: begin
            if (g && !f) begin
              mode[c] = 1; sq[c].delete(); sq[c].push_back(32'(d));
            end
          end
        endcase
      end
      step_a(v, 2'(c), g, f, d);
      chk("rnd rv",    32'(a_rv),    32'(e_rv));
      chk("rnd err",   32'(a_err),   32'(e_er));
      chk("rnd busy",  32'(a_busy),
          32'({mode[3] == 1, mode[2] == 1, mode[1] == 1, mode[0] == 1}));
      chk("rnd chan",  32'(a_rc),    32'(e_rc));
      chk("rnd min",   32'(a_min),   32'(e_min));
      chk("rnd max",   32'(a_max),   32'(e_max));
      chk("rnd range", 32'(a_range), 32'(e_rg));
      chk("rnd count", 32'(a_cnt),   32'(e_ct));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
